mem_controller: RTL and testbench

Round-robin memory controller that shares NUM_CHANNELS external memory channels among NUM_CONSUMERS requesters (per-core LSUs or fetchers). It sits between the cores started by the block dispatcher and the external program/data memory. Each channel runs a small transaction state machine. A consumer is never served by two channels at once. Each transaction ends with a valid/ready release handshake back to the consumer.

---
 rtl/mem_controller.sv | 154 +++++++++++++++
 tb/tb_mem_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller.sv
// Round-robin memory controller: NUM_CHANNELS channels share external memory among
// NUM_CONSUMERS requesters, each channel running a grant/wait/relay transaction FSM.
module mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]  mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]  mem_write_valid,
  output logic [ADDR_BITS-1:0]     mem_write_address [NUM_CHANNELS],
  output logic [DATA_BITS-1:0]     mem_write_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]  mem_write_ready
);

  localparam int          CW  = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int unsigned NC  = NUM_CONSUMERS;
  localparam int unsigned NCH = NUM_CHANNELS;
  localparam logic        WE  = (WRITE_ENABLE != 0);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  state_t                   state [NUM_CHANNELS];
  logic [CW-1:0]            owner [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] busy;
  logic [CW-1:0]            last_grant;

  logic [NUM_CHANNELS-1:0]  grant;
  logic [NUM_CHANNELS-1:0]  grant_read;
  logic [CW-1:0]            grant_idx [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] claimed;
  logic [CW-1:0]            last_grant_next;

  // Channels arbitrate in index order; 'claimed' keeps a consumer off two channels
  // in the same cycle, and every channel scans from the same round-robin origin.
  always_comb begin
    logic          found;
    logic [CW-1:0] cand;
    claimed         = '0;
    grant           = '0;
    grant_read      = '0;
    last_grant_next = last_grant;
    found           = 1'b0;
    cand            = '0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      grant_idx[ch] = '0;
      found         = 1'b0;
      if (state[ch] == IDLE) begin
        for (int unsigned k = 0; k < NC; k++) begin
          cand = CW'((32'(last_grant) + 32'd1 + k) % NC);
          if (!found && !busy[cand] && !claimed[cand] &&
              (consumer_read_valid[cand] || (WE && consumer_write_valid[cand]))) begin
            found          = 1'b1;
            grant[ch]      = 1'b1;
            grant_read[ch] = consumer_read_valid[cand];
            grant_idx[ch]  = cand;
            claimed[cand]  = 1'b1;
          end
        end
      end
      if (grant[ch]) last_grant_next = grant_idx[ch];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= '{default: IDLE};
      owner                <= '{default: '0};
      busy                 <= '0;
      last_grant           <= CW'(NUM_CONSUMERS - 1);
      consumer_read_ready  <= '0;
      consumer_read_data   <= '{default: '0};
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '{default: '0};
      mem_write_valid      <= '0;
      mem_write_address    <= '{default: '0};
      mem_write_data       <= '{default: '0};
    end else begin
      last_grant <= last_grant_next;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        case (state[ch])
          IDLE: begin
            if (grant[ch]) begin
              busy[grant_idx[ch]] <= 1'b1;
              owner[ch]           <= grant_idx[ch];
              if (grant_read[ch]) begin
                mem_read_valid[ch]   <= 1'b1;
                mem_read_address[ch] <= consumer_read_address[grant_idx[ch]];
                state[ch]            <= READ_WAITING;
              end else if (WE) begin
                mem_write_valid[ch]   <= 1'b1;
                mem_write_address[ch] <= consumer_write_address[grant_idx[ch]];
                mem_write_data[ch]    <= consumer_write_data[grant_idx[ch]];
                state[ch]             <= WRITE_WAITING;
              end
            end
          end
          READ_WAITING: begin
            if (mem_read_ready[ch]) begin
              mem_read_valid[ch]               <= 1'b0;
              consumer_read_data[owner[ch]]    <= mem_read_data[ch];
              consumer_read_ready[owner[ch]]   <= 1'b1;
              state[ch]                        <= READ_RELAYING;
            end
          end
          WRITE_WAITING: begin
            if (mem_write_ready[ch]) begin
              mem_write_valid[ch]             <= 1'b0;
              consumer_write_ready[owner[ch]] <= 1'b1;
              state[ch]                       <= WRITE_RELAYING;
            end
          end
          READ_RELAYING: begin
            if (!consumer_read_valid[owner[ch]]) begin
              consumer_read_ready[owner[ch]] <= 1'b0;
              busy[owner[ch]]                <= 1'b0;
              state[ch]                      <= IDLE;
            end
          end
          WRITE_RELAYING: begin
            if (!consumer_write_valid[owner[ch]]) begin
              consumer_write_ready[owner[ch]] <= 1'b0;
              busy[owner[ch]]                 <= 1'b0;
              state[ch]                       <= IDLE;
            end
          end
          default: state[ch] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench: a 2-channel read/write controller and a 1-channel read-only controller.
module tb_mem_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: two channels, writes enabled
  logic [3:0]  a_crv, a_crr, a_cwv, a_cwr;
  logic [7:0]  a_cra [4];
  logic [15:0] a_crd [4];
  logic [7:0]  a_cwa [4];
  logic [15:0] a_cwd [4];
  logic [1:0]  a_mrv, a_mrr, a_mwv, a_mwr;
  logic [7:0]  a_mra [2];
  logic [15:0] a_mrd [2];
  logic [7:0]  a_mwa [2];
  logic [15:0] a_mwd [2];

  // Instance B: one channel, read-only
  logic [3:0]  b_crv, b_crr, b_cwv, b_cwr;
  logic [7:0]  b_cra [4];
  logic [15:0] b_crd [4];
  logic [7:0]  b_cwa [4];
  logic [15:0] b_cwd [4];
  logic [0:0]  b_mrv, b_mrr, b_mwv, b_mwr;
  logic [7:0]  b_mra [1];
  logic [15:0] b_mrd [1];
  logic [7:0]  b_mwa [1];
  logic [15:0] b_mwd [1];

  mem_controller #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4),
                   .NUM_CHANNELS(2), .WRITE_ENABLE(1)) u_a (
    .clk(clk), .reset(reset),
    .consumer_read_valid(a_crv), .consumer_read_address(a_cra),
    .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
    .consumer_write_valid(a_cwv), .consumer_write_address(a_cwa),
    .consumer_write_data(a_cwd), .consumer_write_ready(a_cwr),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
  );

  mem_controller #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4),
                   .NUM_CHANNELS(1), .WRITE_ENABLE(0)) u_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
    .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
    .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
    .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_crv = '0; a_cwv = '0; a_mrr = '0; a_mwr = '0;
    b_crv = '0; b_cwv = '0; b_mrr = '0; b_mwr = '0;
    for (int i = 0; i < 4; i++) begin
      a_cra[i] = '0; a_cwa[i] = '0; a_cwd[i] = '0;
      b_cra[i] = 8'h40 + 8'(i); b_cwa[i] = '0; b_cwd[i] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      a_mrd[i] = '0;
    end
    b_mrd[0] = '0;

    tick(); tick();
    reset = 1'b0;
    check("rst_a_mrv", 32'(a_mrv), 32'h0);
    check("rst_a_mwv", 32'(a_mwv), 32'h0);
    check("rst_a_crr", 32'(a_crr), 32'h0);
    check("rst_a_cwr", 32'(a_cwr), 32'h0);
    check("rst_b_mrv", 32'(b_mrv), 32'h0);

    // Single read: consumer 2 reads 0x10, memory returns 0x1234
    a_crv[2] = 1'b1; a_cra[2] = 8'h10;
    tick();
    check("rd_grant_mrv", 32'(a_mrv), 32'h1);
    check("rd_grant_addr", 32'(a_mra[0]), 32'h10);
    a_mrr[0] = 1'b1; a_mrd[0] = 16'h1234;
    tick();
    a_mrr[0] = 1'b0;
    check("rd_ready", 32'(a_crr), 32'h4);
    check("rd_data", 32'(a_crd[2]), 32'h1234);
    check("rd_mrv_low", 32'(a_mrv), 32'h0);
    tick();
    check("rd_ready_held", 32'(a_crr), 32'h4);
    a_crv[2] = 1'b0;
    tick();
    check("rd_release", 32'(a_crr), 32'h0);

    // Write: consumer 0 writes 0xBEEF to 0x22; later input change must be ignored
    a_cwv[0] = 1'b1; a_cwa[0] = 8'h22; a_cwd[0] = 16'hBEEF;
    tick();
    check("wr_grant_mwv", 32'(a_mwv), 32'h1);
    check("wr_addr", 32'(a_mwa[0]), 32'h22);
    check("wr_data", 32'(a_mwd[0]), 32'hBEEF);
    a_cwd[0] = 16'h1111; a_cwa[0] = 8'h99;
    tick();
    check("wr_latched_data", 32'(a_mwd[0]), 32'hBEEF);
    check("wr_wait_cwr", 32'(a_cwr), 32'h0);
    tick();
    a_mwr[0] = 1'b1;
    tick();
    a_mwr[0] = 1'b0;
    check("wr_ready", 32'(a_cwr), 32'h1);
    check("wr_mwv_low", 32'(a_mwv), 32'h0);
    a_cwv[0] = 1'b0;
    tick();
    check("wr_release", 32'(a_cwr), 32'h0);

    // Parallel: consumers 1 and 3 on channels 0 and 1 in the same cycle
    a_crv[1] = 1'b1; a_cra[1] = 8'h31;
    a_crv[3] = 1'b1; a_cra[3] = 8'h33;
    tick();
    check("par_mrv", 32'(a_mrv), 32'h3);
    check("par_addr0", 32'(a_mra[0]), 32'h31);
    check("par_addr1", 32'(a_mra[1]), 32'h33);
    a_mrr = 2'b11; a_mrd[0] = 16'hAAAA; a_mrd[1] = 16'hBBBB;
    tick();
    a_mrr = 2'b00;
    check("par_ready", 32'(a_crr), 32'hA);
    check("par_data1", 32'(a_crd[1]), 32'hAAAA);
    check("par_data3", 32'(a_crd[3]), 32'hBBBB);
    a_crv[1] = 1'b0; a_crv[3] = 1'b0;
    tick();
    check("par_release", 32'(a_crr), 32'h0);

    // Async reset mid READ_WAITING, then consumer 0 must win first
    a_crv[1] = 1'b1; a_cra[1] = 8'h51;
    tick();
    check("ar_pre_mrv", 32'(a_mrv), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("ar_mrv_async", 32'(a_mrv), 32'h0);
    check("ar_mra_async", 32'(a_mra[0]), 32'h0);
    tick();
    a_crv[0] = 1'b1; a_cra[0] = 8'h50;
    reset = 1'b0;
    tick();
    check("ar_first_ch0", 32'(a_mra[0]), 32'h50);
    check("ar_second_ch1", 32'(a_mra[1]), 32'h51);
    a_crv = '0;

    // Fairness on the single-channel instance: grant order 0,1,2,3,0
    b_crv = 4'hF;
    for (int i = 0; i < 5; i++) begin
      int exp_c;
      exp_c = i % 4;
      tick();
      check("fair_addr", 32'(b_mra[0]), 32'h40 + 32'(exp_c));
      b_mrr[0] = 1'b1; b_mrd[0] = 16'h0100 + 16'(exp_c);
      tick();
      b_mrr[0] = 1'b0;
      check("fair_ready", 32'(b_crr), 32'h1 << exp_c);
      check("fair_data", 32'(b_crd[exp_c]), 32'h100 + 32'(exp_c));
      b_crv[exp_c] = 1'b0;
      tick();
      check("fair_release", 32'(b_crr), 32'h0);
      if (i < 4) b_crv[exp_c] = 1'b1;
    end
    b_crv = '0;

    // Read-only: write request never granted, write outputs stay 0
    b_cwv[1] = 1'b1; b_cwa[1] = 8'h77; b_cwd[1] = 16'hCAFE;
    b_mwr[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ro_mwv", 32'(b_mwv), 32'h0);
      check("ro_mwa", 32'(b_mwa[0]), 32'h0);
      check("ro_mwd", 32'(b_mwd[0]), 32'h0);
      check("ro_cwr", 32'(b_cwr), 32'h0);
      check("ro_mrv", 32'(b_mrv), 32'h0);
    end
    b_cwv = '0; b_mwr = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
